// File: rtl/cplx_op_sequencer.sv
// Single-issue command sequencer for the complex register bank and ALU.
// Accepts one command, strobes the bank reads, waits out the ALU latency,
// then issues the writeback. It only produces control strobes and never
// touches operand data.
module cplx_op_sequencer #(
  parameter int unsigned ALU_LAT  = 2,
  parameter int unsigned CNST_MAX = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [3:0]  cmd_srcA,
  input  logic [3:0]  cmd_srcB,
  input  logic        cmd_cnstA,
  input  logic        cmd_cnstB,
  input  logic [3:0]  cmd_dst,
  input  logic [1:0]  cmd_wmode,
  input  logic        cmd_nowb,
  output logic [3:0]  seloutA,
  output logic [3:0]  seloutB,
  output logic        cnstA,
  output logic        cnstB,
  output logic        enrregA,
  output logic        enrregB,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  output logic        regwen,
  output logic [3:0]  selwreg,
  output logic [1:0]  endwreg,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] ops_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WRITE
  } state_t;

  localparam logic [3:0] EXEC_LOAD = 4'(ALU_LAT - 1);
  localparam logic [3:0] CNST_LIM  = 4'(CNST_MAX);

  state_t      state;
  logic [3:0]  lat_cnt;
  logic [3:0]  dst_q;
  logic [1:0]  wmode_q;
  logic        nowb_q;
  logic        err_q;
  logic        cnst_bad;

  // Out-of-range constant index on either operand, evaluated on the live command
  always_comb begin
    cnst_bad = (cmd_cnstA && (cmd_srcA > CNST_LIM)) ||
               (cmd_cnstB && (cmd_srcB > CNST_LIM));
  end

  // Handshake readiness and busy flag decoded from the state register only
  always_comb begin
    cmd_ready = (state == IDLE) && !reset;
    busy      = (state != IDLE);
  end

  // Sequencer FSM with registered strobes; strobes are loaded one edge early
  // so each one is high for exactly the cycle of the state it belongs to
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      dst_q     <= '0;
      wmode_q   <= '0;
      nowb_q    <= 1'b0;
      err_q     <= 1'b0;
      seloutA   <= '0;
      seloutB   <= '0;
      cnstA     <= 1'b0;
      cnstB     <= 1'b0;
      enrregA   <= 1'b0;
      enrregB   <= 1'b0;
      alu_op    <= '0;
      alu_start <= 1'b0;
      regwen    <= 1'b0;
      selwreg   <= '0;
      endwreg   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      ops_cnt   <= '0;
    end else begin
      seloutA   <= '0;
      seloutB   <= '0;
      cnstA     <= 1'b0;
      cnstB     <= 1'b0;
      enrregA   <= 1'b0;
      enrregB   <= 1'b0;
      alu_start <= 1'b0;
      regwen    <= 1'b0;
      selwreg   <= '0;
      endwreg   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state   <= READ;
            alu_op  <= cmd_op;
            dst_q   <= cmd_dst;
            wmode_q <= cmd_wmode;
            nowb_q  <= cmd_nowb;
            err_q   <= cnst_bad;
            seloutA <= cmd_srcA;
            seloutB <= cmd_srcB;
            cnstA   <= cmd_cnstA;
            cnstB   <= cmd_cnstB;
            enrregA <= 1'b1;
            enrregB <= 1'b1;
          end
        end
        READ: begin
          state     <= EXEC;
          lat_cnt   <= EXEC_LOAD;
          alu_start <= 1'b1;
        end
        EXEC: begin
          if (lat_cnt == '0) begin
            state   <= WRITE;
            regwen  <= !nowb_q;
            selwreg <= nowb_q ? '0 : dst_q;
            endwreg <= nowb_q ? '0 : wmode_q;
            done    <= 1'b1;
            err     <= err_q;
            ops_cnt <= ops_cnt + 16'd1;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        WRITE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cplx_op_sequencer.sv
// Self-checking bench for cplx_op_sequencer: directed scenarios plus random
// commands, checked cycle-by-cycle against a schedule computed from the
// command's acceptance edge.
module tb_cplx_op_sequencer;

  localparam int unsigned L  = 2;
  localparam int unsigned CM = 8;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_srcA;
  logic [3:0]  cmd_srcB;
  logic        cmd_cnstA;
  logic        cmd_cnstB;
  logic [3:0]  cmd_dst;
  logic [1:0]  cmd_wmode;
  logic        cmd_nowb;
  logic [3:0]  seloutA;
  logic [3:0]  seloutB;
  logic        cnstA;
  logic        cnstB;
  logic        enrregA;
  logic        enrregB;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        regwen;
  logic [3:0]  selwreg;
  logic [1:0]  endwreg;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] ops_cnt;

  cplx_op_sequencer #(.ALU_LAT(L), .CNST_MAX(CM)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_srcA(cmd_srcA), .cmd_srcB(cmd_srcB),
    .cmd_cnstA(cmd_cnstA), .cmd_cnstB(cmd_cnstB), .cmd_dst(cmd_dst),
    .cmd_wmode(cmd_wmode), .cmd_nowb(cmd_nowb),
    .seloutA(seloutA), .seloutB(seloutB), .cnstA(cnstA), .cnstB(cnstB),
    .enrregA(enrregA), .enrregB(enrregB), .alu_op(alu_op),
    .alu_start(alu_start), .regwen(regwen), .selwreg(selwreg),
    .endwreg(endwreg), .busy(busy), .done(done), .err(err), .ops_cnt(ops_cnt)
  );

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       ca;
    logic       cb;
    logic [3:0] dst;
    logic [1:0] wm;
    logic       nowb;
  } cmd_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_cnt  = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input int op, input int a, input int b, input int ca,
                              input int cb, input int dst, input int wm, input int nowb);
    cmd_t c;
    c.op = 3'(op); c.a = 4'(a); c.b = 4'(b); c.ca = 1'(ca); c.cb = 1'(cb);
    c.dst = 4'(dst); c.wm = 2'(wm); c.nowb = 1'(nowb);
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    return mk($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
              $urandom_range(0, 3), $urandom_range(0, 1));
  endfunction

  task automatic scramble_fields(input bit valid);
    cmd_valid = valid;
    cmd_op    = 3'($urandom);
    cmd_srcA  = 4'($urandom);
    cmd_srcB  = 4'($urandom);
    cmd_cnstA = 1'($urandom);
    cmd_cnstB = 1'($urandom);
    cmd_dst   = 4'($urandom);
    cmd_wmode = 2'($urandom);
    cmd_nowb  = 1'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check("idle_ready", 32'(cmd_ready), 1);
      check("idle_busy", 32'(busy), 0);
      check("idle_done", 32'(done), 0);
      check("idle_regwen", 32'(regwen), 0);
      check("idle_enrreg", 32'({enrregA, enrregB}), 0);
      check("idle_cnt", 32'(ops_cnt), 32'(exp_cnt));
    end
  endtask

  // Issue one command and check every cycle up to and including its WRITE cycle.
  // keep: leave cmd_valid high (with unrelated field values) afterwards.
  task automatic do_cmd(input cmd_t c, input bit keep);
    bit e;
    int unsigned wr;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op = c.op; cmd_srcA = c.a; cmd_srcB = c.b; cmd_cnstA = c.ca;
    cmd_cnstB = c.cb; cmd_dst = c.dst; cmd_wmode = c.wm; cmd_nowb = c.nowb;
    check("hs_ready", 32'(cmd_ready), 1);
    check("hs_busy", 32'(busy), 0);
    e  = (c.ca && int'(c.a) > CM) || (c.cb && int'(c.b) > CM);
    wr = L + 2;
    @(posedge clock);
    #1 scramble_fields(keep);
    for (int unsigned k = 1; k <= wr; k++) begin
      @(negedge clock);
      check("ready_low", 32'(cmd_ready), 0);
      check("busy", 32'(busy), 1);
      check("enrregA", 32'(enrregA), 32'(k == 1));
      check("enrregB", 32'(enrregB), 32'(k == 1));
      check("seloutA", 32'(seloutA), (k == 1) ? 32'(c.a) : 0);
      check("seloutB", 32'(seloutB), (k == 1) ? 32'(c.b) : 0);
      check("cnstA", 32'(cnstA), (k == 1) ? 32'(c.ca) : 0);
      check("cnstB", 32'(cnstB), (k == 1) ? 32'(c.cb) : 0);
      check("alu_start", 32'(alu_start), 32'(k == 2));
      check("alu_op", 32'(alu_op), 32'(c.op));
      check("regwen", 32'(regwen), 32'(k == wr && !c.nowb));
      check("selwreg", 32'(selwreg), (k == wr && !c.nowb) ? 32'(c.dst) : 0);
      check("endwreg", 32'(endwreg), (k == wr && !c.nowb) ? 32'(c.wm) : 0);
      check("done", 32'(done), 32'(k == wr));
      check("err", 32'(err), 32'(k == wr && e));
      if (k == wr) exp_cnt = (exp_cnt + 1) % 65536;
      check("ops_cnt", 32'(ops_cnt), 32'(exp_cnt));
    end
  endtask

  initial begin
    cmd_t c;
    reset = 1'b1;
    scramble_fields(1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ready", 32'(cmd_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_strobes", 32'({enrregA, enrregB, alu_start, regwen, done, err}), 0);
    check("rst_sel", 32'({seloutA, seloutB, cnstA, cnstB, selwreg, endwreg, alu_op}), 0);
    check("rst_cnt", 32'(ops_cnt), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    idle_cycles(2);

    // Basic command, constant range boundaries, suppressed writeback
    do_cmd(mk(1, 2, 3, 0, 0, 5, 0, 0), 1'b0);
    idle_cycles(1);
    do_cmd(mk(4, 8, 9, 1, 1, 3, 3, 0), 1'b0);
    do_cmd(mk(2, 8, 8, 1, 1, 6, 1, 0), 1'b0);
    do_cmd(mk(5, 9, 15, 0, 0, 2, 2, 0), 1'b0);
    do_cmd(mk(3, 1, 1, 0, 0, 7, 0, 1), 1'b0);
    idle_cycles(1);

    // cmd_valid held high across three commands: accepts L+3 cycles apart
    do_cmd(mk(6, 4, 5, 0, 1, 9, 1, 0), 1'b1);
    do_cmd(mk(7, 10, 0, 1, 0, 11, 2, 0), 1'b1);
    do_cmd(mk(0, 12, 13, 0, 0, 14, 3, 1), 1'b0);
    idle_cycles(2);

    // Reset in the second EXEC cycle aborts the command
    do_cmd_abort();

    // Counter wraparound from 0xFFFF
    @(negedge clock);
    force dut.ops_cnt = 16'hFFFF;
    #1 release dut.ops_cnt;
    exp_cnt = 16'hFFFF;
    idle_cycles(1);
    do_cmd(mk(1, 0, 0, 1, 1, 1, 0, 0), 1'b0);
    check("wrap_cnt", 32'(ops_cnt), 0);

    // Random commands with random gaps or back-to-back valid
    for (int i = 0; i < 40; i++) begin
      bit keep;
      c = rand_cmd();
      keep = (i != 39) && ($urandom_range(0, 1) == 1);
      do_cmd(c, keep);
      if (!keep) idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic do_cmd_abort();
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op = 3'd2; cmd_srcA = 4'd1; cmd_srcB = 4'd2; cmd_cnstA = 1'b0;
    cmd_cnstB = 1'b0; cmd_dst = 4'd3; cmd_wmode = 2'd0; cmd_nowb = 1'b0;
    check("ab_ready", 32'(cmd_ready), 1);
    @(posedge clock);
    #1 scramble_fields(1'b0);
    @(negedge clock);
    check("ab_read", 32'(enrregA), 1);
    @(negedge clock);
    check("ab_start", 32'(alu_start), 1);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("ab_ready_rst", 32'(cmd_ready), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    exp_cnt = 0;
    @(negedge clock);
    check("ab_busy", 32'(busy), 0);
    check("ab_ready_after", 32'(cmd_ready), 1);
    check("ab_regwen", 32'(regwen), 0);
    check("ab_done", 32'(done), 0);
    check("ab_cnt", 32'(ops_cnt), 0);
    idle_cycles(3);
  endtask

endmodule

// File: doc/cplx_op_sequencer.md
Name: cplx_op_sequencer

Overview:
- Single-issue command sequencer for the complex-number register bank (16 x 64-bit entries, {re[63:32], im[31:0]}, constant ROM indices 0-8) and the downstream complex ALU.
- Accepts one operation per command through a valid/ready handshake.
- Drives the bank read ports, waits out the ALU latency, then writes the result back to the bank.
- Sits between the top-level control/host interface and the bank+ALU datapath. It never touches data; it only produces control strobes.

Parameters:
ALU_LAT, 2, fixed ALU latency in cycles from alu_start to result valid on the bank inA bus (legal range 1-15).
CNST_MAX, 8, highest legal constant-ROM index.

Ports:
clock  in  1  master clock, posedge
reset  in  1  synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  3  ALU opcode, passed through to alu_op
cmd_srcA  in  4  operand A register/constant index
cmd_srcB  in  4  operand B register/constant index
cmd_cnstA  in  1  operand A taken from constant ROM
cmd_cnstB  in  1  operand B taken from constant ROM
cmd_dst  in  4  destination register index
cmd_wmode  in  2  write mode forwarded to endwreg (00 full, 01/10 half, 11 swap)
cmd_nowb  in  1  1 = suppress writeback (compare/test ops)
seloutA, seloutB  out  4  bank read selects
cnstA, cnstB  out  1  bank constant selects
enrregA, enrregB  out  1  bank output-register load strobes
alu_op  out  3  latched opcode
alu_start  out  1  one-cycle ALU start pulse
regwen  out  1  bank write strobe
selwreg  out  4  bank write index
endwreg  out  2  bank write mode
busy  out  1  command in flight
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with done when a constant index exceeds CNST_MAX
ops_cnt  out  16  completed-command counter

Behaviour:
- FSM states: IDLE, READ, EXEC, WRITE.
- Reset value of every output is 0, except the select/index fields, which hold 0 while their strobes are low.
- The FSM goes to IDLE on reset. cmd_ready is 0 while reset is high.
- IDLE:
  - cmd_ready = 1, busy = 0.
  - A handshake (cmd_valid & cmd_ready at a posedge) latches all cmd_* fields; the next state is READ.
- READ (1 cycle):
  - enrregA = enrregB = 1.
  - seloutA/B and cnstA/B come from the latched fields.
  - The bank registers its outputs on the edge that ends READ.
  - Next state is EXEC.
- EXEC (ALU_LAT cycles):
  - alu_start = 1 in the first EXEC cycle only.
  - alu_op is held stable for the whole command.
  - A down-counter loaded with ALU_LAT-1 is decremented each cycle; at 0 the next state is WRITE.
- WRITE (1 cycle):
  - If cmd_nowb = 0, regwen = 1 with selwreg = dst and endwreg = wmode.
  - If cmd_nowb = 1, regwen stays 0.
  - done = 1, ops_cnt increments (wraps 0xFFFF to 0), next state is IDLE.
- Latency: the handshake edge is followed by READ (1) + EXEC (ALU_LAT) + WRITE (1). done is high in cycle ALU_LAT+2 after the handshake edge.
- Throughput: one command per ALU_LAT+3 cycles. No back-to-back overlap, so no read-after-write hazard exists.
- busy = 1 in READ, EXEC and WRITE.
- cmd_ready is 0 outside IDLE. cmd_valid held high while not ready is ignored; the command is accepted once the FSM returns to IDLE.
- err:
  - Computed at latch time: (cnstA & srcA > CNST_MAX) | (cnstB & srcB > CNST_MAX).
  - The command still executes (bank supplies its default).
  - err pulses in the same cycle as done.
- All strobes (enrreg*, alu_start, regwen, done, err) are exactly one cycle wide and never overlap across states.
- Reset mid-operation:
  - Returns to IDLE on the next edge and drops all strobes.
  - No writeback is issued for the aborted command and ops_cnt is cleared.
- Control outputs are registered or decoded from state only. No combinational path runs from cmd_* to bank controls.

Test Plan:
- Reset, then cmd op=1 srcA=2 srcB=3 dst=5 wmode=00 nowb=0, ALU_LAT=2 -> enrregA/B in cycle 1 with sel 2/3, alu_start in cycle 2, regwen in cycle 4 with selwreg=5 endwreg=00, done in cycle 4, ops_cnt=1.
- cnstA=1 srcA=8, cnstB=1 srcB=9 -> full sequence runs, err=1 in the done cycle. With srcB=8 instead, err=0.
- nowb=1, dst=7 -> done pulses, regwen never asserts, ops_cnt increments.
- cmd_valid held high for 3 commands -> accepts spaced exactly ALU_LAT+3 cycles apart, cmd_ready low in between, each command's fields latched correctly.
- Reset asserted in the second EXEC cycle -> no regwen or done, busy=0 and cmd_ready=1 on the first cycle after reset deasserts, ops_cnt=0.
- Preload ops_cnt to 0xFFFF via 65535 commands (or a forced bench value), then one more command -> ops_cnt=0x0000.
